imem_loader: RTL and testbench
==============================

# imem_loader

Serial program loader that fills the instruction memory at run time, as an alternative to the simulation-time hex-file preload. It accepts a byte stream over a valid/ready handshake, assembles little-endian instruction words, and issues one write per word to the instruction memory's write port at sequential word addresses starting at 0. While loading, it holds the processor in reset through `cpu_hold`.

## Interface
- `n`, 32: instruction word width in bits; must be a multiple of 8.
- `r`, 6: word-address width; memory depth is 2**r words.

- `clk`  in  1  single system clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begins a load session; sampled only in IDLE.
- `len`  in  r+1  number of words to load; sampled with `start`; legal range 0..2**r.
- `byte_valid`  in  1  source has a byte on `byte_data`.
- `byte_data`  in  8  stream byte.
- `byte_ready`  out  1  loader will accept a byte this cycle.
- `mem_we`  out  1  write strobe to instruction memory, one cycle per word.
- `mem_addr`  out  r  word address of the current write.
- `mem_wdata`  out  n  assembled instruction word.
- `busy`  out  1  session in progress (RECV or WRITE).
- `done`  out  1  one-cycle pulse when a session completes.
- `cpu_hold`  out  1  processor reset request; equals `busy`.
- `word_count`  out  r+1  words written in the current or most recent session.

## Operation
- States: IDLE, RECV, WRITE, DONE.
- IDLE: `byte_ready`=0. On `start`=1, latch `len` and clear `word_count`, address, and byte index. If `len`=0, go to DONE; otherwise go to RECV.
- RECV: `byte_ready`=1. A byte is accepted when `byte_valid`&&`byte_ready`. Byte k (k=0..n/8-1) goes to `mem_wdata[8k+7:8k]`, so the first byte is the LSB. Accepting byte n/8-1 moves to WRITE. With `byte_valid`=0 the loader waits indefinitely and holds all state.
- WRITE: `byte_ready`=0, `mem_we`=1, with `mem_addr` and `mem_wdata` stable. Next edge: `word_count`+1, `mem_addr`+1, byte index cleared. If the new `word_count`==`len`, go to DONE; otherwise go to RECV.
- DONE: `done`=1 for exactly one cycle, then IDLE. `word_count` and `mem_wdata` hold until the next `start`.
- `start` outside IDLE is ignored.
- `len`=2**r: the last write goes to address 2**r-1 and `mem_addr` wraps to 0. `word_count` is r+1 bits wide, so it reaches 2**r without overflow.
- Bytes offered in IDLE, WRITE, or DONE are not accepted; the source must hold them.

## Timing
- Reset values: IDLE, `byte_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `done`=0, `cpu_hold`=0, `word_count`=0.
- Reset asserted mid-session aborts immediately. The partial word is discarded, no `mem_we` is issued, and `done` is not pulsed. Words already written remain in memory.
- All outputs are registered or decoded from the state register; there are no combinational input-to-output paths.
- `busy`/`cpu_hold` rise the cycle after `start` is sampled and fall on entry to DONE.
- Throughput with `byte_valid` held high: n/8 accept cycles plus 1 write cycle per word, i.e. 5 cycles per word at n=32.
- A session of L≥1 words with no stalls lasts 1 (start) + 5L + 1 (DONE) cycles.
- `len`=0: `done` pulses 1 cycle after `start` and `busy` never asserts.

## Test plan
- Reset then idle: hold `reset_n`=0 for 3 cycles, release, run 10 cycles -> all outputs 0 and `byte_ready`=0 throughout.
- Single word: `start` with `len`=1, stream bytes 0x13,0x00,0x10,0x20 back-to-back -> exactly one `mem_we` with `mem_addr`=0 and `mem_wdata`=0x20100013; `done` 6 cycles after `start`; `word_count`=1.
- Stalled stream: `len`=3, insert 2-cycle `byte_valid` gaps between bytes of words 0x8C010004, 0x00221820, 0xAC030008 -> writes at addresses 0,1,2 with those values in order; no extra writes; one `done` pulse.
- Full depth with wrap: `len`=64, word i = i*0x01010101 -> 64 writes to addresses 0..63; `mem_addr` returns to 0; `word_count`=64; `start` pulses during the session are ignored.
- Mid-session reset: `len`=2, assert `reset_n`=0 after word 0 is written and 2 bytes of word 1 are accepted -> no second `mem_we`; outputs return to reset values; a fresh session with `len`=1 then writes address 0 correctly.
- `len`=0: `start` -> `done` pulse next cycle, zero writes, `busy` never asserts, `word_count`=0.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: serial byte-stream loader for the instruction memory.
// Assembles little-endian words from a valid/ready byte stream and writes
// them to sequential word addresses from 0, holding the CPU in reset meanwhile.
module imem_loader #(
  parameter int unsigned n = 32,
  parameter int unsigned r = 6
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [r:0]   len,
  input  logic         byte_valid,
  input  logic [7:0]   byte_data,
  output logic         byte_ready,
  output logic         mem_we,
  output logic [r-1:0] mem_addr,
  output logic [n-1:0] mem_wdata,
  output logic         busy,
  output logic         done,
  output logic         cpu_hold,
  output logic [r:0]   word_count
);

  localparam int unsigned NB = n / 8;
  localparam int unsigned BW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t        state, state_nxt;
  logic [r:0]    len_q;
  logic [r:0]    wc_inc;
  logic [BW-1:0] byte_idx;
  logic          last_byte;

  assign wc_inc    = word_count + (r+1)'(1);
  assign last_byte = (byte_idx == BW'(NB - 1));

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; all outputs decode from the state register only
  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    cpu_hold   = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (len == '0) ? DONE : RECV;
      end
      RECV: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        cpu_hold   = 1'b1;
        if (byte_valid && last_byte) state_nxt = WRITE;
      end
      WRITE: begin
        mem_we    = 1'b1;
        busy      = 1'b1;
        cpu_hold  = 1'b1;
        state_nxt = (wc_inc == len_q) ? DONE : RECV;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: session setup, byte assembly, address/count advance
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_q      <= '0;
      word_count <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      byte_idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len_q      <= len;
            word_count <= '0;
            mem_addr   <= '0;
            byte_idx   <= '0;
          end
        end
        RECV: begin
          if (byte_valid) begin
            mem_wdata[int'(byte_idx)*8 +: 8] <= byte_data;
            if (!last_byte) byte_idx <= byte_idx + BW'(1);
          end
        end
        WRITE: begin
          word_count <= wc_inc;
          mem_addr   <= mem_addr + r'(1);
          byte_idx   <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader (n=32, r=6).
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [6:0]  len;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        cpu_hold;
  logic [6:0]  word_count;

  imem_loader #(.n(32), .r(6)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .len(len),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .cpu_hold(cpu_hold), .word_count(word_count)
  );

  always #5 clk = ~clk;

  logic [49:0] outs;
  assign outs = {byte_ready, mem_we, mem_addr, mem_wdata, busy, done, cpu_hold, word_count};

  int pass_cnt = 0;
  int total    = 0;

  // Observation log, written only by the monitor
  int          cyc = 0;
  int          wr_n = 0;
  logic [5:0]  wr_addr [0:1023];
  logic [31:0] wr_data [0:1023];
  int          done_n = 0;
  int          done_cyc = 0;
  int          busy_n = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr[wr_n] = mem_addr;
      wr_data[wr_n] = mem_wdata;
      wr_n = wr_n + 1;
    end
    if (done) begin
      done_n   = done_n + 1;
      done_cyc = cyc;
    end
    if (busy) busy_n = busy_n + 1;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [6:0] l, output int s);
    start = 1'b1;
    len   = l;
    s     = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok = 0;
    byte_valid = 1'b0;
    repeat (gap) tick();
    byte_valid = 1'b1;
    byte_data  = b;
    for (int i = 0; i < 50; i++) begin
      if (byte_ready) begin
        ok = 1;
        tick();
        break;
      end
      tick();
    end
    byte_valid = 1'b0;
    if (!ok) begin
      total++;
      $display("FAIL byte_accept_timeout: byte %h not accepted within 50 cycles, required acceptance", b);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 0; k < 4; k++) send_byte(w[k*8 +: 8], gap);
  endtask

  task automatic wait_done(input int base);
    bit ok = 0;
    for (int i = 0; i < 30; i++) begin
      if (done_n > base) begin
        ok = 1;
        break;
      end
      tick();
    end
    tick();
    if (!ok) begin
      total++;
      $display("FAIL done_timeout: no done pulse within 30 cycles, required one");
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; len = '0; byte_valid = 1'b0; byte_data = '0;
    repeat (3) tick();
    total++;
    if (outs !== '0) $display("FAIL reset_outputs: got %h want 0", outs); else pass_cnt++;
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (outs !== '0) $display("FAIL idle_outputs[%0d]: got %h want 0", i, outs); else pass_cnt++;
    end
  endtask

  task automatic test_single_word();
    int wb = wr_n, db = done_n, s;
    do_start(7'd1, s);
    send_word(32'h20100013, 0);
    wait_done(db);
    total++;
    if (wr_n - wb !== 1) $display("FAIL single_writes: got %0d want 1", wr_n - wb); else pass_cnt++;
    total++;
    if (wr_addr[wb] !== 6'd0) $display("FAIL single_addr: got %0d want 0", wr_addr[wb]); else pass_cnt++;
    total++;
    if (wr_data[wb] !== 32'h20100013) $display("FAIL single_data: got %h want 20100013", wr_data[wb]); else pass_cnt++;
    total++;
    if (done_cyc - s !== 6) $display("FAIL single_done_latency: got %0d want 6", done_cyc - s); else pass_cnt++;
    total++;
    if (word_count !== 7'd1) $display("FAIL single_word_count: got %0d want 1", word_count); else pass_cnt++;
    total++;
    if (busy !== 1'b0 || cpu_hold !== 1'b0) $display("FAIL single_busy_after: got %b%b want 00", busy, cpu_hold); else pass_cnt++;
  endtask

  task automatic test_stalled();
    int wb = wr_n, db = done_n, s;
    logic [31:0] w [0:2];
    w[0] = 32'h8C010004; w[1] = 32'h00221820; w[2] = 32'hAC030008;
    do_start(7'd3, s);
    for (int i = 0; i < 3; i++) send_word(w[i], 2);
    wait_done(db);
    repeat (5) tick();
    total++;
    if (wr_n - wb !== 3) $display("FAIL stall_writes: got %0d want 3", wr_n - wb); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (wr_addr[wb+i] !== 6'(i) || wr_data[wb+i] !== w[i])
        $display("FAIL stall_write[%0d]: got %0d:%h want %0d:%h", i, wr_addr[wb+i], wr_data[wb+i], i, w[i]);
      else pass_cnt++;
    end
    total++;
    if (done_n - db !== 1) $display("FAIL stall_done_pulses: got %0d want 1", done_n - db); else pass_cnt++;
    total++;
    if (word_count !== 7'd3) $display("FAIL stall_word_count: got %0d want 3", word_count); else pass_cnt++;
  endtask

  task automatic test_full_depth();
    int wb = wr_n, db = done_n, s;
    do_start(7'd64, s);
    for (int i = 0; i < 64; i++) begin
      start = (i == 10 || i == 40);
      send_word(32'(i) * 32'h01010101, 0);
    end
    start = 1'b0;
    wait_done(db);
    repeat (3) tick();
    total++;
    if (wr_n - wb !== 64) $display("FAIL full_writes: got %0d want 64", wr_n - wb); else pass_cnt++;
    for (int i = 0; i < 64; i++) begin
      total++;
      if (wr_addr[wb+i] !== 6'(i) || wr_data[wb+i] !== 32'(i) * 32'h01010101)
        $display("FAIL full_write[%0d]: got %0d:%h want %0d:%h", i, wr_addr[wb+i], wr_data[wb+i], i, 32'(i) * 32'h01010101);
      else pass_cnt++;
    end
    total++;
    if (mem_addr !== 6'd0) $display("FAIL full_addr_wrap: got %0d want 0", mem_addr); else pass_cnt++;
    total++;
    if (word_count !== 7'd64) $display("FAIL full_word_count: got %0d want 64", word_count); else pass_cnt++;
    total++;
    if (done_n - db !== 1) $display("FAIL full_done_pulses: got %0d want 1", done_n - db); else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    int wb = wr_n, db = done_n, s;
    do_start(7'd2, s);
    send_word(32'h11223344, 0);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    reset_n = 1'b0;
    #1;
    total++;
    if (outs !== '0) $display("FAIL midreset_async: got %h want 0", outs); else pass_cnt++;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (6) tick();
    total++;
    if (wr_n - wb !== 1) $display("FAIL midreset_writes: got %0d want 1", wr_n - wb); else pass_cnt++;
    total++;
    if (done_n !== db) $display("FAIL midreset_done: got %0d pulses want 0", done_n - db); else pass_cnt++;
    total++;
    if (outs !== '0) $display("FAIL midreset_outputs: got %h want 0", outs); else pass_cnt++;
    wb = wr_n;
    db = done_n;
    do_start(7'd1, s);
    send_word(32'hDEADBEEF, 0);
    wait_done(db);
    total++;
    if (wr_n - wb !== 1 || wr_addr[wb] !== 6'd0 || wr_data[wb] !== 32'hDEADBEEF)
      $display("FAIL midreset_fresh: got %0d writes %0d:%h want 1 writes 0:deadbeef", wr_n - wb, wr_addr[wb], wr_data[wb]);
    else pass_cnt++;
  endtask

  task automatic test_len_zero();
    int wb = wr_n, db = done_n, bb = busy_n, s;
    do_start(7'd0, s);
    wait_done(db);
    repeat (3) tick();
    total++;
    if (done_n - db !== 1) $display("FAIL len0_done_pulses: got %0d want 1", done_n - db); else pass_cnt++;
    total++;
    if (done_cyc - s !== 1) $display("FAIL len0_done_latency: got %0d want 1", done_cyc - s); else pass_cnt++;
    total++;
    if (wr_n !== wb) $display("FAIL len0_writes: got %0d want 0", wr_n - wb); else pass_cnt++;
    total++;
    if (busy_n !== bb) $display("FAIL len0_busy: got %0d busy cycles want 0", busy_n - bb); else pass_cnt++;
    total++;
    if (word_count !== 7'd0) $display("FAIL len0_word_count: got %0d want 0", word_count); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_stalled();
    test_full_depth();
    test_mid_reset();
    test_len_zero();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit, required completion");
    $fatal(1, "timeout");
  end

endmodule
